// File: rtl/text_overlay_ctrl.sv
// Text overlay controller: 32x4 character buffer, command port and scanline read path.
// Optional cursor blink: define TEXT_OVL_CURSOR_BLINK_EN.
module text_overlay_ctrl #(
    parameter logic [8:0] ORIGIN_Y = 9'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_cmd,
    input  logic [6:0] wr_data,
    input  logic       pix_en,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    output logic [5:0] gen_char,
    output logic [2:0] gen_row,
    input  logic [7:0] gen_pixels,
    output logic       ovl_pixel,
    output logic       ovl_valid
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [5:0] SPACE = 6'd38;

    state_t     state;
    logic [6:0] clr_idx;
    logic [4:0] cur_col;
    logic [1:0] cur_row;
    logic [5:0] buffer [128];

    logic       fire;
    logic [5:0] put_val;

    assign fire    = wr_valid & wr_ready;
    assign put_val = (wr_data[5:0] > SPACE) ? SPACE : wr_data[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_idx  <= 7'd0;
            cur_col  <= 5'd0;
            cur_row  <= 2'd0;
            wr_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        case (wr_cmd)
                            2'b00: {cur_row, cur_col} <= {cur_row, cur_col} + 7'd1;
                            2'b01: begin
                                cur_col <= wr_data[4:0];
                                cur_row <= wr_data[6:5];
                            end
                            2'b10: begin
                                state    <= CLEAR;
                                clr_idx  <= 7'd0;
                                cur_col  <= 5'd0;
                                cur_row  <= 2'd0;
                                wr_ready <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    clr_idx <= clr_idx + 7'd1;
                    if (clr_idx == 7'd127) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Contents need no reset: reset always starts a full clear sweep.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            buffer[clr_idx] <= SPACE;
        else if (fire && wr_cmd == 2'b00)
            buffer[{cur_row, cur_col}] <= put_val;
    end

    logic       win;
    logic [4:0] dy;
    logic       lit;
    logic       inv;

    assign dy  = vpos[4:0] - ORIGIN_Y[4:0];
    assign win = !hpos[8] && (vpos >= ORIGIN_Y) &&
                 ({1'b0, vpos} < ({1'b0, ORIGIN_Y} + 10'd32));

    assign gen_char = win ? buffer[{dy[4:3], hpos[7:3]}] : 6'd0;
    assign gen_row  = win ? dy[2:0] : 3'd0;
    assign lit      = gen_pixels[~hpos[2:0]] & win;

`ifdef TEXT_OVL_CURSOR_BLINK_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= 5'd0;
        else if (pix_en && hpos == 9'd0 && vpos == 9'd0)
            frame_cnt <= frame_cnt + 5'd1;
    end

    assign inv = win && frame_cnt[4] &&
                 (hpos[7:3] == cur_col) && (dy[4:3] == cur_row);
`else
    assign inv = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovl_pixel <= 1'b0;
            ovl_valid <= 1'b0;
        end else if (pix_en) begin
            ovl_pixel <= lit ^ inv;
            ovl_valid <= win;
        end
    end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Directed bench for text_overlay_ctrl with a small behavioural glyph ROM.
module tb_text_overlay_ctrl;

    localparam logic [8:0] OY = 9'd8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_cmd = 2'b00;
    logic [6:0] wr_data = 7'd0;
    logic       pix_en = 1'b0;
    logic [8:0] hpos = 9'd300;
    logic [8:0] vpos = 9'd300;
    logic [5:0] gen_char;
    logic [2:0] gen_row;
    logic [7:0] gen_pixels;
    logic       ovl_pixel;
    logic       ovl_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_overlay_ctrl #(.ORIGIN_Y(OY)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_cmd(wr_cmd), .wr_data(wr_data),
        .pix_en(pix_en), .hpos(hpos), .vpos(vpos),
        .gen_char(gen_char), .gen_row(gen_row),
        .gen_pixels(gen_pixels),
        .ovl_pixel(ovl_pixel), .ovl_valid(ovl_valid)
    );

    // Glyph ROM: space is blank, char 10 is 8'h38 on every row.
    always_comb begin
        gen_pixels = {gen_char, gen_row[1:0]};
        if (gen_char == 6'd38) gen_pixels = 8'h00;
        if (gen_char == 6'd10) gen_pixels = 8'h38;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [6:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_cmd   = c;
        wr_data  = d;
        while (!wr_ready && n < 300) begin
            tick();
            n++;
        end
        if (!wr_ready) check("send_timeout", 0, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!wr_ready && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic pix(input logic [8:0] h, input logic [8:0] v);
        hpos   = h;
        vpos   = v;
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
    endtask

    task automatic peek(input logic [8:0] h, input logic [8:0] v);
        hpos = h;
        vpos = v;
        #1;
    endtask

    int n;
    logic [7:0] exp_seq;

    initial begin
        tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_ovl_valid", ovl_valid, 0);
        check("rst_ovl_pixel", ovl_pixel, 0);
        rst = 1'b0;

        wait_ready(n);
        check("init_clear_len", n, 128);

        for (int i = 0; i < 6; i++) begin
            pix(9'(i * 45), OY + 9'(i * 6));
            check("blank_valid", ovl_valid, 1);
            check("blank_pixel", ovl_pixel, 0);
        end

        send(2'b01, 7'h7F);
        send(2'b00, 7'd10);
        peek(9'd250, OY + 9'd24);
        check("c31_3_char", gen_char, 10);
        check("c31_3_row", gen_row, 0);
        exp_seq = 8'b00111000;
        for (int i = 0; i < 8; i++) begin
            pix(9'(248 + i), OY + 9'd24);
            check("glyph_seq", ovl_pixel, int'(exp_seq[7 - i]));
        end

        send(2'b00, 7'd50);
        send(2'b00, 7'd5);
        peek(9'd3, OY + 9'd2);
        check("clamp_00", gen_char, 38);
        check("row_sel", gen_row, 2);
        peek(9'd9, OY);
        check("adv_10", gen_char, 5);

        send(2'b11, 7'd33);
        send(2'b00, 7'd7);
        peek(9'd17, OY + 9'd1);
        check("rsvd_noop", gen_char, 7);

        pix(9'd256, OY + 9'd3);
        check("out_h_valid", ovl_valid, 0);
        check("out_h_pixel", ovl_pixel, 0);
        peek(9'd256, OY + 9'd3);
        check("out_h_char", gen_char, 0);
        pix(9'd8, OY - 9'd1);
        check("out_v_valid", ovl_valid, 0);
        peek(9'd8, OY - 9'd1);
        check("out_v_char", gen_char, 0);
        check("out_v_row", gen_row, 0);
        peek(9'd8, OY + 9'd32);
        check("out_vhi_char", gen_char, 0);

        // CLEAR with a PUT queued right behind it.
        send(2'b10, 7'd0);
        wr_valid = 1'b1;
        wr_cmd   = 2'b00;
        wr_data  = 7'd20;
        wait_ready(n);
        check("clear_len", n, 128);
        peek(9'd9, OY);
        check("cleared_10", gen_char, 38);
        tick();
        wr_valid = 1'b0;
        peek(9'd1, OY);
        check("queued_put_00", gen_char, 20);
        peek(9'd9, OY);
        check("after_put_10", gen_char, 38);

        // Reset in the middle of a clear restarts the sweep.
        send(2'b10, 7'd0);
        repeat (10) tick();
        rst = 1'b1;
        #2;
        check("midrst_ready", wr_ready, 0);
        rst = 1'b0;
        wait_ready(n);
        check("midrst_len", n, 128);
        peek(9'd1, OY);
        check("midrst_00", gen_char, 38);

        send(2'b00, 7'd3);
        send(2'b01, 7'd0);

`ifdef TEXT_OVL_CURSOR_BLINK_EN
        for (int f = 0; f < 32; f++) begin
            pix(9'd0, OY);
            check("blink_frame", ovl_pixel, (f >= 16) ? 1 : 0);
            pix(9'd0, 9'd0);
        end
`else
        for (int f = 0; f < 20; f++) begin
            pix(9'd0, OY);
            check("no_blink", ovl_pixel, 0);
            pix(9'd0, 9'd0);
        end
`endif
        pix(9'd4, OY);
        check("cell00_px4", ovl_pixel, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
